// File: rtl/pack_ram_ctrl.sv
// Byte packer feeding a word RAM, with a burst read port (IDLE -> FETCH -> OUT).
// Incoming bytes are assembled into BPW-byte words and written at wr_ptr; reads return
// rd_len+1 consecutive words starting at addr, wrapping at DEPTH.
module pack_ram_ctrl #(
    parameter int BYTE_W = 8,
    parameter int BPW    = 4,
    parameter int DEPTH  = 64,
    parameter int ENDIAN = 0,
    parameter int LEN_W  = 3,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int WORD_W = BYTE_W * BPW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              addr_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr
);

    localparam int               CNT_W = $clog2(BPW);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BPW - 1);

    typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lane;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              mem_we;
    logic [WORD_W-1:0] mem_q [DEPTH];

    // Byte k of a word lands in lane k, or in the mirrored lane for big-endian packing.
    always_comb lane = (ENDIAN != 0) ? LAST - cnt_q : cnt_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        wr_ptr_d  = wr_ptr_q;
        rd_addr_d = rd_addr_q;
        len_d     = len_q;
        mem_we    = 1'b0;

        // Bytes are only taken while idle; the counter survives gaps in in_valid.
        if (in_valid && state_q == IDLE) begin
            word_d[int'(lane)*BYTE_W +: BYTE_W] = in_data;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                // A byte in the same cycle wins; the read request is dropped.
                if (addr_valid && !in_valid) begin
                    state_d   = FETCH;
                    rd_addr_d = addr;
                    len_d     = rd_len;
                end
            end
            FETCH: state_d = OUT;
            OUT: begin
                if (len_q == '0) begin
                    state_d = IDLE;
                end else begin
                    len_d     = len_q - LEN_W'(1);
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            wr_ptr_q  <= '0;
            rd_addr_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_addr_q <= rd_addr_d;
            len_q     <= len_d;
        end
    end

    // NOTE: the storage must read back zero after reset, so it is built from resettable flops
    // rather than a RAM macro, which cannot be cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? mem_q[rd_addr_q] : '0;
    assign wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_pack_ram_ctrl.sv
// Randomized bench for pack_ram_ctrl: two instances (little/big endian) checked every cycle
// against a byte/word-level model, plus directed scenarios pinned to literal values.
module tb_pack_ram_ctrl;

    localparam int BYTE_W = 8;
    localparam int BPW    = 4;
    localparam int DEPTH  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        addr_valid = 1'b0;
    logic [5:0]  addr = '0;
    logic [2:0]  rd_len = '0;

    logic        out_valid0, out_valid1, busy0, busy1;
    logic [31:0] out_data0, out_data1;
    logic [5:0]  wr_ptr0, wr_ptr1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pack_ram_ctrl #(.BYTE_W(BYTE_W), .BPW(BPW), .DEPTH(DEPTH), .ENDIAN(0), .LEN_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .addr_valid(addr_valid), .addr(addr), .rd_len(rd_len),
        .out_valid(out_valid0), .out_data(out_data0), .busy(busy0), .wr_ptr(wr_ptr0)
    );

    pack_ram_ctrl #(.BYTE_W(BYTE_W), .BPW(BPW), .DEPTH(DEPTH), .ENDIAN(1), .LEN_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .addr_valid(addr_valid), .addr(addr), .rd_len(rd_len),
        .out_valid(out_valid1), .out_data(out_data1), .busy(busy1), .wr_ptr(wr_ptr1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        bit          valid;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem1 [DEPTH];
    logic [7:0]  pend [BPW];
    int          bcnt;
    int          wp;
    exp_t        exp_q [$];
    exp_t        cur;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        bcnt = 0;
        wp   = 0;
        exp_q.delete();
        cur = '{0, 0, 32'h0, 32'h0};
    endtask

    // Each entry of exp_q describes one future cycle; cur is the cycle now in progress.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                if (!cur.busy && in_valid) begin
                    pend[bcnt] = in_data;
                    bcnt++;
                    if (bcnt == BPW) begin
                        logic [31:0] w0, w1;
                        for (int k = 0; k < BPW; k++) begin
                            w0[k*8 +: 8]         = pend[k];
                            w1[(BPW-1-k)*8 +: 8] = pend[k];
                        end
                        mem0[wp] = w0;
                        mem1[wp] = w1;
                        wp   = (wp + 1) % DEPTH;
                        bcnt = 0;
                    end
                end else if (!cur.busy && addr_valid) begin
                    exp_q.push_back('{1, 0, 32'h0, 32'h0});
                    for (int i = 0; i <= int'(rd_len); i++) begin
                        int a;
                        a = (int'(addr) + i) % DEPTH;
                        exp_q.push_back('{1, 1, mem0[a], mem1[a]});
                    end
                end
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else                  cur = '{0, 0, 32'h0, 32'h0};
            end
        end
    end

    // Every cycle: all outputs of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("out_valid0", 64'(out_valid0), 64'(cur.valid));
            check("out_data0",  64'(out_data0),  64'(cur.d0));
            check("busy0",      64'(busy0),      64'(cur.busy));
            check("wr_ptr0",    64'(wr_ptr0),    64'(wp));
            check("out_valid1", 64'(out_valid1), 64'(cur.valid));
            check("out_data1",  64'(out_data1),  64'(cur.d1));
            check("busy1",      64'(busy1),      64'(cur.busy));
            check("wr_ptr1",    64'(wr_ptr1),    64'(wp));
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] cap0 [$];
    logic [31:0] cap1 [$];

    task automatic drive(input bit iv, input logic [7:0] d, input bit av,
                         input logic [5:0] a, input logic [2:0] l);
        in_valid   = iv;
        in_data    = d;
        addr_valid = av;
        addr       = a;
        rd_len     = l;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 8'h0, 0, 6'h0, 3'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(1, b, 0, 6'h0, 3'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid0), 64'h0);
        check({tag, "_out_data"},  64'(out_data0),  64'h0);
        check({tag, "_busy"},      64'(busy0),      64'h0);
        check({tag, "_wr_ptr"},    64'(wr_ptr0),    64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        addr_valid = 1'b0;
        #1 check_reset_outputs("rst_during");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_held");
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_after");
    endtask

    // Issue one read, optionally hammering inputs while busy; collect words and busy cycles.
    task automatic read_burst(input logic [5:0] a, input logic [2:0] l, input bit noise,
                              output int nw, output int nb);
        bit done;
        cap0.delete();
        cap1.delete();
        nb   = 0;
        done = 1'b0;
        drive(0, 8'h0, 1, a, l);
        for (int c = 0; c < 40 && !done; c++) begin
            if (out_valid0) begin
                cap0.push_back(out_data0);
                cap1.push_back(out_data1);
            end
            if (!busy0) begin
                done = 1'b1;
            end else begin
                nb++;
                if (noise) drive(1, 8'($urandom), 1, 6'($urandom), 3'($urandom));
                else       drive(0, 8'h0, 0, 6'h0, 3'h0);
            end
        end
        in_valid   = 1'b0;
        addr_valid = 1'b0;
        check("burst_terminates", 64'(done), 64'h1);
        nw = cap0.size();
    endtask

    initial begin
        int nw, nb;

        // Reset behaviour
        do_reset();

        // Packing: bytes 01..08, read two words from address 0
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        read_burst(6'd0, 3'd1, 0, nw, nb);
        check("pack_words",   64'(nw),      64'd2);
        check("pack_le_w0",   64'(cap0[0]), 64'h04030201);
        check("pack_le_w1",   64'(cap0[1]), 64'h08070605);
        check("pack_be_w0",   64'(cap1[0]), 64'h01020304);
        check("pack_be_w1",   64'(cap1[1]), 64'h05060708);
        check("pack_wr_ptr",  64'(wr_ptr0), 64'd2);

        // Wrap: 64 full words bring wr_ptr back to 0; read across the end of memory
        do_reset();
        for (int i = 0; i < 256; i++) send_byte(8'($urandom));
        check("wrap_wr_ptr", 64'(wr_ptr0), 64'd0);
        read_burst(6'd62, 3'd3, 0, nw, nb);
        check("wrap_words", 64'(nw), 64'd4);
        check("wrap_busy",  64'(nb), 64'd5);

        // Partial word resumes after idle gap; read right after completing byte
        do_reset();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        idle(5);
        send_byte(8'hDD);
        read_burst(6'd0, 3'd0, 0, nw, nb);
        check("partial_words", 64'(nw),      64'd1);
        check("partial_le",    64'(cap0[0]), 64'hDDCCBBAA);
        check("partial_be",    64'(cap1[0]), 64'hAABBCCDD);

        // Conflicts: byte + read together, then inputs hammered during a burst
        drive(1, 8'h11, 1, 6'd0, 3'd0);
        check("inv_addr_no_burst", 64'(busy0), 64'h0);
        read_burst(6'd0, 3'd3, 1, nw, nb);
        check("busy_single_burst", 64'(nw),      64'd4);
        check("busy_wr_ptr_held",  64'(wr_ptr0), 64'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        read_burst(6'd1, 3'd0, 0, nw, nb);
        check("conflict_word", 64'(cap0[0]), 64'h44332211);
        check("conflict_wr_ptr", 64'(wr_ptr0), 64'd2);

        // Reset in the middle of an 8-word burst
        drive(0, 8'h0, 1, 6'd0, 3'd7);
        idle(3);
        check("midrst_in_out", 64'(out_valid0), 64'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        check("midrst_be_out_data", 64'(out_data1), 64'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        read_burst(6'd0, 3'd1, 0, nw, nb);
        check("midrst_words", 64'(nw),      64'd2);
        check("midrst_ram0",  64'(cap0[0]), 64'h0);
        check("midrst_ram1",  64'(cap0[1]), 64'h0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0),
                  6'($urandom), 3'($urandom));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pack_ram_ctrl.md
PACK_RAM_CTRL -- requirements
Module: pack_ram_ctrl

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, bits per input byte.
REQ-002 SHALL have parameter BPW, default 4, bytes per stored word (power of 2, >=2).
REQ-003 SHALL have parameter DEPTH, default 64, number of words (power of 2); ADDR_W = log2(DEPTH).
REQ-004 SHALL have parameter ENDIAN, default 0; 0 = first received byte in LSBs, 1 = first received byte in MSBs.
REQ-005 SHALL have parameter LEN_W, default 3, width of the burst-length field.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  in_data valid this cycle.
REQ-009 in_data  input  BYTE_W  byte to pack.
REQ-010 addr_valid  input  1  single-cycle read request strobe.
REQ-011 addr  input  ADDR_W  start word address, sampled with addr_valid.
REQ-012 rd_len  input  LEN_W  burst length minus one, sampled with addr_valid.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_data  output  BYTE_W*BPW  read word.
REQ-015 busy  output  1  read burst in progress.
REQ-016 wr_ptr  output  ADDR_W  address the next completed word is written to.

Function
REQ-017 SHALL sample in_data on every rising edge with in_valid=1 and busy=0, placing byte k (k = 0..BPW-1, in arrival order) at bits [k*BYTE_W +: BYTE_W] when ENDIAN=0, at byte lane BPW-1-k when ENDIAN=1.
REQ-018 SHALL keep the byte counter across in_valid gaps; a partial word resumes with the next accepted byte; only rst_n clears it.
REQ-019 SHALL write the word into RAM[wr_ptr] on the same edge that accepts its BPW-th byte, and increment wr_ptr on that edge, modulo DEPTH (63 -> 0 overwrites word 0).
REQ-020 SHALL implement states IDLE, FETCH, OUT; IDLE->FETCH on addr_valid=1 with in_valid=0; FETCH->OUT after one cycle; OUT holds for rd_len+1 cycles, then ->IDLE.
REQ-021 SHALL assert busy in FETCH and OUT, deassert in IDLE.
REQ-022 SHALL assert out_valid for exactly rd_len+1 consecutive cycles, first cycle being the second cycle after the addr_valid cycle.
REQ-023 SHALL output RAM[(addr+i) mod DEPTH] in output cycle i; address wraps past DEPTH-1 to 0.
REQ-024 SHALL drive out_data to all zeros whenever out_valid=0.
REQ-025 SHALL ignore addr_valid while busy=1 (no queueing, no effect on current burst).
REQ-026 SHALL ignore in_valid while busy=1 (bytes dropped, counter and wr_ptr unchanged).
REQ-027 SHALL ignore addr_valid when in_valid=1 in the same cycle; the byte is accepted.
REQ-028 SHALL return the newly written word for a read whose addr_valid arrives in the cycle after the word-completing byte.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, out_data=0, busy=0, wr_ptr=0, byte counter=0, state=IDLE, all RAM words=0, regardless of clock.
REQ-030 SHALL abort any burst in progress on reset assertion with no further out_valid after release.

Verification
REQ-031 Reset: pulse rst_n low 2 cycles -> out_valid=0, out_data=0, busy=0, wr_ptr=0 during and after reset.
REQ-032 Packing: bytes 01..08, then addr=0 rd_len=1 -> two out_valid cycles 32'h04030201, 32'h08070605 (ENDIAN=1: 32'h01020304, 32'h05060708); wr_ptr=2.
REQ-033 Wrap: 256 random bytes, wr_ptr=0; addr=62 rd_len=3 -> 4 words RAM[62],RAM[63],RAM[0],RAM[1] matching model, busy high 5 cycles.
REQ-034 Partial word: bytes AA,BB,CC, 5 idle cycles, byte DD; read addr 0 -> 32'hDDCCBBAA.
REQ-035 Conflicts: addr_valid during busy -> ignored, single burst only; in_valid+addr_valid same cycle -> byte packed, no burst; in_valid while busy -> byte dropped, wr_ptr unchanged.
REQ-036 Reset mid-burst: rst_n low during OUT of rd_len=7 burst -> out_valid/out_data 0 immediately, RAM reads 0 afterwards.
